// File: rtl/zero_pad_shifter_pkg.sv
// Shared types and constants for the zero-reinsertion shifter.
// ZERO_PAD_SHIFT4_EN widens the per-cycle shift step from 1 to 4 bits.
package zero_pad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } zps_state_t;

   localparam int unsigned ZPS_WIDTH  = 32;
   localparam int unsigned ZPS_CNT_W  = 6;
   localparam int unsigned ZPS_STEP_W = 3;

`ifdef ZERO_PAD_SHIFT4_EN
   localparam int unsigned ZPS_MAX_STEP = 4;
`else
   localparam int unsigned ZPS_MAX_STEP = 1;
`endif

   // Counts beyond the word width behave exactly like a full-width shift.
   function automatic logic [ZPS_CNT_W-1:0] zps_sat_count(input logic [ZPS_CNT_W-1:0] count);
      if (count > ZPS_CNT_W'(ZPS_WIDTH)) begin
         return ZPS_CNT_W'(ZPS_WIDTH);
      end else begin
         return count;
      end
   endfunction

endpackage

// File: rtl/zero_pad_shifter_if.sv
// Request/response bundle between the shifter and its producer/consumer.
interface zero_pad_shifter_if;
   import zero_pad_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [ZPS_WIDTH-1:0] in_data;
   logic [ZPS_CNT_W-1:0] in_count;
   logic                 in_leading;
   logic                 out_valid;
   logic                 out_ready;
   logic [ZPS_WIDTH-1:0] out_data;
   logic                 out_sticky;

   modport master (
      output in_valid, in_data, in_count, in_leading, out_ready,
      input  in_ready, out_valid, out_data, out_sticky
   );

   modport slave (
      input  in_valid, in_data, in_count, in_leading, out_ready,
      output in_ready, out_valid, out_data, out_sticky
   );

endinterface

// File: rtl/zero_pad_shifter_step.sv
// Combinational single-step shifter: moves the word by 0..4 bits with zero fill
// and flags whether any discarded bit was set.
module zps_step
   import zero_pad_pkg::*;
(
   input  logic [ZPS_WIDTH-1:0]  data,
   input  logic                  leading,
   input  logic [ZPS_STEP_W-1:0] step,
   output logic [ZPS_WIDTH-1:0]  shifted,
   output logic                  sticky
);

   logic [ZPS_WIDTH-1:0] drop_mask_s;

   // Shift toward the active end and mask the bits that fall off it
   always_comb begin
      shifted     = {ZPS_WIDTH{1'b0}};
      drop_mask_s = {ZPS_WIDTH{1'b0}};
      if (leading) begin
         shifted     = data >> step;
         drop_mask_s = ~({ZPS_WIDTH{1'b1}} << step);
      end else begin
         shifted     = data << step;
         drop_mask_s = ~({ZPS_WIDTH{1'b1}} >> step);
      end
      sticky = |(data & drop_mask_s);
   end

endmodule

// File: rtl/zero_pad_shifter.sv
// Sequential zero-reinsertion shifter: inserts a count of leading or trailing zeros,
// one step per cycle. ZERO_PAD_SHIFT4_EN enables 4-bit steps (same results, lower latency).
module zero_pad_shifter
   import zero_pad_pkg::*;
#(
   parameter int WIDTH = ZPS_WIDTH,
   parameter int CNT_W = ZPS_CNT_W
)(
   input logic               clk,
   input logic               rst_n,
   zero_pad_shifter_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX_STEP_C = CNT_W'(ZPS_MAX_STEP);

   zps_state_t              state_r;
   zps_state_t              state_next_s;
   logic [WIDTH-1:0]        data_r;
   logic [CNT_W-1:0]        remaining_r;
   logic                    leading_r;
   logic                    sticky_r;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic [CNT_W-1:0]        sat_count_s;
   logic [ZPS_STEP_W-1:0]   step_s;
   logic [WIDTH-1:0]        step_data_s;
   logic                    step_sticky_s;

   assign sat_count_s    = zps_sat_count(bus.in_count);
   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = data_r;
   assign bus.out_sticky = sticky_r;

   // Step size: the configured maximum, trimmed so the final step lands exactly on zero
   always_comb begin
      step_s = {ZPS_STEP_W{1'b0}};
      if (remaining_r > MAX_STEP_C) begin
         step_s = ZPS_STEP_W'(ZPS_MAX_STEP);
      end else begin
         step_s = remaining_r[ZPS_STEP_W-1:0];
      end
   end

   zps_step u_step (
      .data    (data_r),
      .leading (leading_r),
      .step    (step_s),
      .shifted (step_data_s),
      .sticky  (step_sticky_s)
   );

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!bus.in_valid) begin
               state_next_s = IDLE;
            end else if (sat_count_s == {CNT_W{1'b0}}) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         SHIFT: begin
            if (remaining_r == CNT_W'(step_s)) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, handshake flags and datapath registers; reset discards any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         data_r      <= {WIDTH{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
         leading_r   <= 1'b0;
         sticky_r    <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == IDLE);
         out_valid_r <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  data_r      <= bus.in_data;
                  remaining_r <= sat_count_s;
                  leading_r   <= bus.in_leading;
                  sticky_r    <= 1'b0;
               end
            end
            SHIFT: begin
               data_r      <= step_data_s;
               sticky_r    <= sticky_r | step_sticky_s;
               remaining_r <= remaining_r - CNT_W'(step_s);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zero_pad_shifter.sv
// Self-checking bench for zero_pad_shifter: directed table, randomized requests
// against an arithmetic reference, backpressure and mid-shift reset sequences.
module tb_zero_pad_shifter;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   zero_pad_shifter_if bus();

   zero_pad_shifter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  count;
      logic        leading;
      logic [31:0] exp_data;
      logic        exp_sticky;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input int n);
`ifdef ZERO_PAD_SHIFT4_EN
      return 1 + (n + 3) / 4;
`else
      return 1 + n;
`endif
   endfunction

   // Reference: whole-word shift in 64-bit arithmetic; discarded bits are whatever leaves the 32-bit window
   function automatic void ref_model(input logic [31:0] d, input int c, input logic lead,
                                     output logic [31:0] r, output logic s);
      logic [63:0] wide;
      int n;
      n = (c > 32) ? 32 : c;
      if (lead) begin
         wide = 64'(d) >> n;
         r    = wide[31:0];
         s    = ((64'(d) & ((64'd1 << n) - 64'd1)) != 64'd0);
      end else begin
         wide = 64'(d) << n;
         r    = wide[31:0];
         s    = (wide[63:32] != 32'd0);
      end
   endfunction

   task automatic run_req(input string name, input logic [31:0] d, input logic [5:0] c,
                          input logic lead, input logic [31:0] ed, input logic es);
      int lat;
      int n;
      n = (c > 6'd32) ? 32 : int'(c);
      @(negedge clk);
      check({name, "/in_ready_before"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid   = 1'b1;
      bus.in_data    = d;
      bus.in_count   = c;
      bus.in_leading = lead;
      bus.out_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.in_data    = $urandom;
      bus.in_count   = 6'($urandom);
      bus.in_leading = 1'($urandom);
      lat = 0;
      while (lat < 80) begin
         lat++;
         @(negedge clk);
         if (bus.out_valid) break;
      end
      check({name, "/latency"}, 64'(lat), 64'(exp_latency(n)));
      check({name, "/data"}, 64'(bus.out_data), 64'(ed));
      check({name, "/sticky"}, 64'(bus.out_sticky), 64'(es));
      @(posedge clk);
      #1;
      check({name, "/in_ready_after"}, 64'(bus.in_ready), 64'd1);
      check({name, "/out_valid_after"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] ed;
      logic        es;
      logic [5:0]  rc;
      logic        rl;
      int          lat;

      bus.in_valid   = 1'b0;
      bus.in_data    = 32'd0;
      bus.in_count   = 6'd0;
      bus.in_leading = 1'b0;
      bus.out_ready  = 1'b1;
      rst_n          = 1'b0;

      vecs[0]  = '{32'h8000_0001, 6'd4,  1'b1, 32'h0800_0000, 1'b1};
      vecs[1]  = '{32'h0000_00FF, 6'd8,  1'b0, 32'h0000_FF00, 1'b0};
      vecs[2]  = '{32'hF000_0000, 6'd1,  1'b0, 32'hE000_0000, 1'b1};
      vecs[3]  = '{32'hDEAD_BEEF, 6'd0,  1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{32'hFFFF_FFFF, 6'd45, 1'b1, 32'h0000_0000, 1'b1};
      vecs[5]  = '{32'hFFFF_FFFF, 6'd32, 1'b1, 32'h0000_0000, 1'b1};
      vecs[6]  = '{32'h0000_0000, 6'd32, 1'b0, 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h1234_5678, 6'd63, 1'b0, 32'h0000_0000, 1'b1};
      vecs[8]  = '{32'h8000_0000, 6'd31, 1'b1, 32'h0000_0001, 1'b0};
      vecs[9]  = '{32'h0000_0001, 6'd31, 1'b0, 32'h8000_0000, 1'b0};
      vecs[10] = '{32'h0000_0003, 6'd31, 1'b0, 32'h8000_0000, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("reset/in_ready", 64'(bus.in_ready), 64'd1);
      check("reset/out_valid", 64'(bus.out_valid), 64'd0);
      check("reset/out_data", 64'(bus.out_data), 64'd0);
      check("reset/out_sticky", 64'(bus.out_sticky), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].count, vecs[i].leading,
                 vecs[i].exp_data, vecs[i].exp_sticky);
      end

      for (int i = 0; i < 40; i++) begin
         rd = $urandom;
         if (i % 4 == 1) rd = rd & 32'h0000_FFFF;
         if (i % 4 == 2) rd = rd & 32'hFFFF_0000;
         rc = 6'($urandom_range(0, 63));
         rl = 1'($urandom);
         ref_model(rd, int'(rc), rl, ed, es);
         run_req($sformatf("rand%0d", i), rd, rc, rl, ed, es);
      end

      // Backpressure: result must hold in DONE and new requests must be ignored
      @(negedge clk);
      bus.out_ready  = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_data    = 32'h0000_00F0;
      bus.in_count   = 6'd4;
      bus.in_leading = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (lat < 80) begin
         lat++;
         @(negedge clk);
         if (bus.out_valid) break;
      end
      check("bp/latency", 64'(lat), 64'(exp_latency(4)));
      for (int k = 0; k < 3; k++) begin
         bus.in_valid   = 1'b1;
         bus.in_data    = 32'hA5A5_0000 + 32'(k);
         bus.in_count   = 6'd0;
         bus.in_leading = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp%0d/out_valid", k), 64'(bus.out_valid), 64'd1);
         check($sformatf("bp%0d/in_ready", k), 64'(bus.in_ready), 64'd0);
         check($sformatf("bp%0d/data", k), 64'(bus.out_data), 64'h0000_000F);
         check($sformatf("bp%0d/sticky", k), 64'(bus.out_sticky), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp/release_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp/release_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("bp/no_phantom_accept", 64'(bus.in_ready), 64'd1);

      // Reset during SHIFT aborts the request at once
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_data    = 32'hFFFF_FFFF;
      bus.in_count   = 6'd20;
      bus.in_leading = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("rst/mid_in_ready", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("rst/out_valid", 64'(bus.out_valid), 64'd0);
      check("rst/in_ready", 64'(bus.in_ready), 64'd1);
      check("rst/out_data", 64'(bus.out_data), 64'd0);
      check("rst/out_sticky", 64'(bus.out_sticky), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req("post_reset", 32'hFFFF_0000, 6'd20, 1'b1, 32'h0000_0FFF, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/zero_pad_shifter.md
# zero_pad_shifter

Sequential zero-reinsertion shifter, the inverse of leading/trailing zero counting. It accepts a 32-bit word, a 6-bit zero count and a direction flag. It shifts the word so that exactly `count` zeros are inserted at the MSB end (leading) or the LSB end (trailing), and reports a sticky OR of every discarded bit. It sits in the ALU beside the zero counter and is used for denormalisation and for restoring the alignment of a previously normalised operand.

## Interface
- `WIDTH`, 32: data width; must be 32 in this revision.
- `CNT_W`, 6: count width, equal to $clog2(WIDTH)+1.
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: the block can accept a request.
- `in_data` in 32: word to shift.
- `in_count` in 6: number of zeros to insert.
- `in_leading` in 1: 1 inserts leading zeros (logical shift right); 0 inserts trailing zeros (shift left).
- `out_valid` out 1: result valid.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out 32: shifted word.
- `out_sticky` out 1: OR of all bits shifted out.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept occurs when `in_valid && in_ready`:
  - Load the data register with `in_data`.
  - Load the remaining-count register with min(`in_count`, 32). Values 33..63 saturate to 32.
  - Latch the direction and clear sticky.
  - Go to SHIFT if the saturated count is nonzero, otherwise go to DONE.
- Each SHIFT cycle:
  - Shift by step = 1 bit (see Configuration), toward LSB if leading, toward MSB if trailing.
  - Fill vacated positions with 0.
  - OR the discarded bits into sticky.
  - remaining -= step.
  - When remaining reaches 0, go to DONE.
- DONE: hold `out_data` and `out_sticky` stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- No accept-while-DONE bypass. Ignore `in_valid` outside IDLE. Input fields are sampled only on the accept cycle.
- Count 32 always yields `out_data` = 0 and `out_sticky` = |`in_data`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_data` 0, `out_sticky` 0, internal counters 0.
- Accept at edge T gives `out_valid` high after edge T+1+n, where n = saturated count and one bit is shifted per cycle.
  - n = 0: `out_valid` after T+1.
  - n = 32: `out_valid` after T+33.
- After the output handshake at edge D, `in_ready` is high from D onward. The minimum request-to-request spacing is n+2 cycles.
- `out_ready` may already be high when DONE is entered; completion then takes one cycle in DONE.
- Reset asserted mid-operation aborts immediately. Outputs return to their reset values asynchronously and any in-flight result is discarded.

## Configuration
- `ZERO_PAD_SHIFT4_EN`:
  - Defined: step = min(4, remaining). Latency is 1 + ceil(n/4) cycles, so count 32 completes in 9 cycles after accept. Sticky covers all discarded bits of each multi-bit step.
  - Undefined: step = 1, latency 1 + n.
- Results (`out_data`, `out_sticky`) are identical in both builds; only latency differs.

## Structure
- Package `zero_pad_pkg` holds:
  - `zps_state_t` enum (IDLE, SHIFT, DONE).
  - `ZPS_WIDTH` = 32 and `ZPS_CNT_W` = 6.
  - `ZPS_MAX_STEP` (1, or 4 under the macro).
- Sub-module `zps_step`: combinational step shifter.
  - Inputs: data, direction, step amount (0..4).
  - Outputs: shifted data and step sticky.
  - Instantiated once, in the SHIFT datapath.
- The top level holds the FSM, the remaining counter, and the data and sticky registers.

## Test plan
- **Leading shift:** `in_data`=0x8000_0001, count 4, leading -> `out_data` 0x0800_0000, sticky 1, `out_valid` 5 cycles after accept (2 with macro).
- **Trailing shift:** `in_data`=0x0000_00FF, count 8, trailing -> `out_data` 0x0000_FF00, sticky 0. Then 0xF000_0000, count 1, trailing -> 0xE000_0000, sticky 1.
- **Count 0:** `in_data`=0xDEAD_BEEF, count 0 -> identical output, sticky 0, `out_valid` one cycle after accept.
- **Saturation:** count 45 and count 32, leading, `in_data`=0xFFFF_FFFF -> `out_data` 0, sticky 1, latency 33 cycles (9 with macro). Count 32 with `in_data`=0 -> `out_data` 0, sticky 0.
- **Backpressure:** hold `out_ready` low for 3 cycles while in DONE -> `out_data` and `out_sticky` stable, `in_ready` 0, and `in_valid` pulses ignored. Release `out_ready` -> IDLE next cycle.
- **Reset mid-shift:** assert `rst_n` low during SHIFT of a count-20 request -> `out_valid` 0, `in_ready` 1, `out_data` 0 immediately. Then release reset and check that a fresh request completes correctly.
